// File: rtl/led_pulse_stretch_pkg.sv
// ---------------------------------------------------------------------------
// led_pulse_stretch_pkg
// Shared board-test definitions used by the LED pulse stretcher and by the
// input debouncer on the same board.
//   - state_t     : pulse stretcher state encoding (2'b11 is illegal)
//   - N_DEFAULT   : default ON-time counter width (2^21 cycles ~ 42 ms)
//   - G_DEFAULT   : default gap counter width, same timing as the debouncer
//   - P_DEFAULT   : default pending-event counter width
//   - CLK_PERIOD_NS : board clock period (50 MHz), for reference only
// ---------------------------------------------------------------------------
package led_pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ON   = 2'b01,
        GAP  = 2'b10
    } state_t;

    localparam int N_DEFAULT     = 21;
    localparam int G_DEFAULT     = 21;
    localparam int P_DEFAULT     = 3;
    localparam int CLK_PERIOD_NS = 20;

endpackage

// File: rtl/led_pulse_stretch_if.sv
// ---------------------------------------------------------------------------
// led_pulse_stretch_if
// Event/status bundle of the LED pulse stretcher.
//   tick     : single-cycle event strobe            (master -> slave)
//   clr      : synchronous clear of pending/overflow (master -> slave)
//   led      : stretched, registered LED pulse      (slave -> master)
//   busy     : pulse/gap running or events queued   (slave -> master)
//   pending  : queued events not yet displayed      (slave -> master)
//   overflow : sticky, an event was dropped         (slave -> master)
// ---------------------------------------------------------------------------
interface led_pulse_stretch_if
    import led_pulse_stretch_pkg::*;
#(
    parameter int P = P_DEFAULT
);
    logic         tick;
    logic         clr;
    logic         led;
    logic         busy;
    logic [P-1:0] pending;
    logic         overflow;

    modport master (
        output tick, clr,
        input  led, busy, pending, overflow
    );

    modport slave (
        input  tick, clr,
        output led, busy, pending, overflow
    );
endinterface

// File: rtl/led_pulse_stretch_pulse_timer.sv
// ---------------------------------------------------------------------------
// pulse_timer
// W-bit loadable down-counter used for the ON and GAP intervals.
//   clk, reset : clock, asynchronous active-high reset (counter -> 0)
//   load       : load load_val (has priority over en)
//   en         : decrement by one; ignored once the counter is zero
//   load_val   : value loaded on load
//   value      : current count
//   zero       : count is zero
// ---------------------------------------------------------------------------
module pulse_timer #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign value = cnt;
    assign zero  = (cnt == '0);
endmodule

// File: rtl/led_pulse_stretch.sv
// ---------------------------------------------------------------------------
// led_pulse_stretch
// Stretches single-cycle event ticks into LED pulses of exactly 2^N cycles,
// each followed by a dark gap of exactly 2^G cycles. Ticks arriving while a
// pulse or gap runs are queued in a saturating P-bit pending counter; a tick
// lost at saturation sets a sticky overflow flag.
//   clk   : system clock (50 MHz board clock)
//   reset : asynchronous active-high reset
//   io    : led_pulse_stretch_if.slave (tick, clr in; led, busy, pending,
//           overflow out)
// ---------------------------------------------------------------------------
module led_pulse_stretch
    import led_pulse_stretch_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int G = G_DEFAULT,
    parameter int P = P_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    led_pulse_stretch_if.slave    io
);
    localparam logic [N-1:0] ON_LOAD  = '1;
    localparam logic [G-1:0] GAP_LOAD = '1;
    localparam logic [P-1:0] PEND_MAX = '1;

    state_t       state;
    state_t       state_nxt;
    logic         led_q;
    logic [P-1:0] pending_q;
    logic         overflow_q;
    logic         start;

    logic         on_load,  on_en,  on_zero;
    logic         gap_load, gap_en, gap_zero;
    logic [N-1:0] on_val;
    logic [G-1:0] gap_val;

    // Saturating pending update: a start consumes one event, a tick adds
    // one. A tick and start together cancel, so a tick that starts a pulse
    // directly never passes through the queue.
    function automatic logic [P-1:0] pend_sat_next(input logic [P-1:0] cur,
                                                   input logic         add,
                                                   input logic         take);
        if (add && !take) begin
            return (cur == PEND_MAX) ? cur : cur + 1'b1;
        end else if (!add && take) begin
            return cur - 1'b1;
        end
        return cur;
    endfunction

    pulse_timer #(.W(N)) u_on_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (on_load),
        .en       (on_en),
        .load_val (ON_LOAD),
        .value    (on_val),
        .zero     (on_zero)
    );

    pulse_timer #(.W(G)) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .en       (gap_en),
        .load_val (GAP_LOAD),
        .value    (gap_val),
        .zero     (gap_zero)
    );

    // A new pulse may begin from IDLE, or straight out of the final GAP
    // cycle so that queued events follow with exactly one gap between them.
    assign start = ((state == IDLE) || ((state == GAP) && gap_zero)) &&
                   (io.tick || (pending_q != '0));

    always_comb begin
        state_nxt = state;
        on_load   = 1'b0;
        gap_load  = 1'b0;
        on_en     = (state == ON)  && (on_val  != '0);
        gap_en    = (state == GAP) && (gap_val != '0);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ON;
                    on_load   = 1'b1;
                end
            end
            ON: begin
                if (on_zero) begin
                    state_nxt = GAP;
                    gap_load  = 1'b1;
                end
            end
            GAP: begin
                if (gap_zero) begin
                    if (start) begin
                        state_nxt = ON;
                        on_load   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // led is registered from the next state so it rises in the cycle
    // right after the starting tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            led_q <= 1'b0;
        end else begin
            state <= state_nxt;
            led_q <= (state_nxt == ON);
        end
    end

    // clr wins over a coincident tick; a running pulse or gap is unaffected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else if (io.clr) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q <= pend_sat_next(pending_q, io.tick, start);
            if (io.tick && !start && (pending_q == PEND_MAX)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign io.led      = led_q;
    assign io.busy     = (state != IDLE) || (pending_q != '0);
    assign io.pending  = pending_q;
    assign io.overflow = overflow_q;
endmodule
